game_sequencer: RTL and testbench

Top-level game controller for the brick-breaker design. Sequences a game through idle, serve, play, pause, miss, win and game-over phases. Generates the step enable that advances the ball and score blocks, and the serve pulse that recentres the ball. Tracks remaining lives, detects a missed ball against the paddle, and detects a cleared brick field from the 56-bit brick map.

---
 rtl/game_sequencer.sv | 175 +++++++++++++++++
 tb/tb_game_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: top-level brick-breaker game controller.
// Runs the idle/serve/play/pause/miss/win/over phases and produces the
// game-step enable, serve pulse, score clear and lives count.
module game_sequencer #(
    parameter int STEP_DIV    = 25_000_000,
    parameter int SERVE_TICKS = 4,
    parameter int MISS_TICKS  = 4,
    parameter int LIVES       = 3,
    parameter int PADDLE_W    = 4,
    parameter int ROW_BOTTOM  = 14
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_btn,
    input  logic [55:0] Bricks,
    input  logic [3:0]  Ball_rowIndex,
    input  logic [3:0]  Ball_colIndex,
    input  logic [3:0]  paddle_col,
    output logic        step_en,
    output logic        serve,
    output logic        score_clr_n,
    output logic [1:0]  lives,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_MISS  = 3'd4,
        S_WIN   = 3'd5,
        S_OVER  = 3'd6
    } state_t;

    localparam int              DIV_W      = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(STEP_DIV - 1);
    localparam logic [2:0]      SERVE_LAST = 3'(SERVE_TICKS - 1);
    localparam logic [2:0]      MISS_LAST  = 3'(MISS_TICKS - 1);
    localparam logic [1:0]      LIVES_INIT = 2'(LIVES);
    localparam logic [4:0]      PAD_W5     = 5'(PADDLE_W);
    localparam logic [3:0]      ROW_B      = 4'(ROW_BOTTOM);

    logic             sync1_q, sync2_q, sync3_q, start_p_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       phase_q, phase_d;
    state_t           state_q, state_d;
    logic [1:0]       lives_q, lives_d;
    logic             step_en_q, step_en_d;
    logic             serve_q, serve_d;
    logic             score_clr_n_q, score_clr_n_d;

    logic tick, hit, miss, clear;
    logic [4:0] ball_col5, pad_lo5, pad_hi5;

    // Paddle window is compared in 5 bits so a paddle running off the
    // right edge is simply truncated instead of wrapping to column 0.
    assign ball_col5 = {1'b0, Ball_colIndex};
    assign pad_lo5   = {1'b0, paddle_col};
    assign pad_hi5   = pad_lo5 + PAD_W5;
    assign hit       = (ball_col5 >= pad_lo5) && (ball_col5 < pad_hi5);
    assign miss      = (Ball_rowIndex == ROW_B) && !hit;
    assign clear     = (Bricks == 56'd0);
    assign tick      = (div_q == DIV_MAX);

    // Button synchronizer, rising-edge detector and registered start pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            start_p_q <= 1'b0;
        end else begin
            sync1_q   <= start_btn;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            start_p_q <= sync2_q & ~sync3_q;
        end
    end

    // Next-state, divider, phase, lives and one-cycle pulse decisions.
    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        phase_d       = phase_q;
        div_d         = tick ? '0 : div_q + 1'b1;
        step_en_d     = 1'b0;
        serve_d       = 1'b0;
        score_clr_n_d = 1'b1;
        case (state_q)
            S_IDLE, S_WIN, S_OVER: begin
                if (start_p_q) begin
                    state_d       = S_SERVE;
                    lives_d       = LIVES_INIT;
                    score_clr_n_d = 1'b0;
                    div_d         = '0;
                    phase_d       = 3'd0;
                end
            end
            S_SERVE: begin
                if (tick) begin
                    if (phase_q == SERVE_LAST) begin
                        state_d = S_PLAY;
                        serve_d = 1'b1;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end
            end
            S_PLAY: begin
                // A pause request wins over a coincident tick, so the
                // tick that leaves PLAY never produces a step.
                if (start_p_q) begin
                    state_d = S_PAUSE;
                    div_d   = '0;
                end else if (tick) begin
                    if (clear) begin
                        state_d = S_WIN;
                    end else if (miss) begin
                        state_d = S_MISS;
                        lives_d = lives_q - 2'd1;
                        phase_d = 3'd0;
                    end else begin
                        step_en_d = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (start_p_q) begin
                    state_d = S_PLAY;
                    div_d   = '0;
                end
            end
            S_MISS: begin
                if (tick) begin
                    if (phase_q == MISS_LAST) begin
                        state_d = (lives_q == 2'd0) ? S_OVER : S_SERVE;
                        phase_d = 3'd0;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            lives_q       <= LIVES_INIT;
            phase_q       <= 3'd0;
            div_q         <= '0;
            step_en_q     <= 1'b0;
            serve_q       <= 1'b0;
            score_clr_n_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            phase_q       <= phase_d;
            div_q         <= div_d;
            step_en_q     <= step_en_d;
            serve_q       <= serve_d;
            score_clr_n_q <= score_clr_n_d;
        end
    end

    assign step_en     = step_en_q;
    assign serve       = serve_q;
    assign score_clr_n = score_clr_n_q;
    assign lives       = lives_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed bench for game_sequencer with a pulse
// scoreboard (expected pulse cycles queued by the stimulus, observed
// pulse cycles queued by a monitor) plus direct state/lives checks.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_btn = 1'b0;
    logic [55:0] bricks;
    logic [3:0]  row, col, pad;
    logic        step_en, serve, score_clr_n;
    logic [1:0]  lives;
    logic [2:0]  state;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int exp_q[$];
    int obs_q[$];
    int c, e, e2, e3;

    localparam int K_SERVE = 100000;
    localparam int K_CLR   = 200000;

    game_sequencer #(
        .STEP_DIV(4), .SERVE_TICKS(2), .MISS_TICKS(2), .LIVES(2),
        .PADDLE_W(4), .ROW_BOTTOM(14)
    ) dut (
        .clock(clk), .reset(rst_n), .start_btn(start_btn), .Bricks(bricks),
        .Ball_rowIndex(row), .Ball_colIndex(col), .paddle_col(pad),
        .step_en(step_en), .serve(serve), .score_clr_n(score_clr_n),
        .lives(lives), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log the cycle of every output pulse.
    always @(negedge clk) begin
        if (step_en === 1'b1)     obs_q.push_back(cyc);
        if (serve === 1'b1)       obs_q.push_back(K_SERVE + cyc);
        if (score_clr_n === 1'b0) obs_q.push_back(K_CLR + cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
        $display("[TB] cyc=%0d %s observed=%0d expected=%0d", cyc, tag, obs, expv);
    endtask

    task automatic sb_check(input string tag);
        chk({tag, " pulse count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk({tag, " pulse"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic press(output int pc);
        pc = cyc;
        start_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_btn = 1'b0;
    endtask

    initial begin
        bricks = '1; row = 4'd0; col = 4'd0; pad = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset state", state, 0);
        chk("reset lives", lives, 2);
        chk("reset step_en", step_en, 0);
        chk("reset serve", serve, 0);
        chk("reset score_clr_n", score_clr_n, 1);
        rst_n = 1'b1;
        wait_until(cyc + 10);
        chk("idle state", state, 0);
        sb_check("idle");

        // Start a game: clear, serve, then steps every 4 cycles.
        press(c);
        wait_until(c + 3);
        chk("pre-serve state", state, 0);
        e = c + 4;
        exp_q.push_back(K_CLR + e);
        exp_q.push_back(K_SERVE + e + 8);
        exp_q.push_back(e + 12);
        exp_q.push_back(e + 16);
        exp_q.push_back(e + 20);
        wait_until(e);
        chk("serve state", state, 1);
        chk("serve lives", lives, 2);
        wait_until(e + 8);
        chk("play state", state, 2);
        wait_until(e + 21);
        sb_check("start");

        // First miss (column 3 left of paddle at 4).
        row = 4'd14; col = 4'd3; pad = 4'd4;
        wait_until(e + 24);
        chk("miss1 state", state, 4);
        chk("miss1 lives", lives, 1);
        row = 4'd0;
        wait_until(e + 31);
        chk("miss1 hold state", state, 4);
        wait_until(e + 32);
        chk("miss1 reserve state", state, 1);
        exp_q.push_back(K_SERVE + e + 40);
        wait_until(e + 41);
        row = 4'd14;
        wait_until(e + 44);
        chk("miss2 state", state, 4);
        chk("miss2 lives", lives, 0);
        row = 4'd0;
        wait_until(e + 52);
        chk("over state", state, 6);
        wait_until(e + 72);
        sb_check("miss");

        // Paddle hit window edges, then a miss just left of it.
        press(c);
        e2 = c + 4;
        row = 4'd14; col = 4'd7; pad = 4'd4;
        exp_q.push_back(K_CLR + e2);
        exp_q.push_back(K_SERVE + e2 + 8);
        exp_q.push_back(e2 + 12);
        exp_q.push_back(e2 + 16);
        wait_until(e2);
        chk("restart state", state, 1);
        chk("restart lives", lives, 2);
        wait_until(e2 + 13);
        chk("hit col7 state", state, 2);
        pad = 4'd13; col = 4'd15;
        wait_until(e2 + 17);
        chk("hit col15 state", state, 2);
        col = 4'd12;
        wait_until(e2 + 20);
        chk("miss col12 state", state, 4);
        chk("miss col12 lives", lives, 1);
        row = 4'd0;
        exp_q.push_back(K_SERVE + e2 + 36);

        // Cleared field beats a simultaneous miss.
        wait_until(e2 + 37);
        bricks = '0; row = 4'd14; col = 4'd0; pad = 4'd4;
        wait_until(e2 + 40);
        chk("win state", state, 5);
        chk("win lives", lives, 1);
        bricks = '1; row = 4'd0;
        wait_until(e2 + 42);
        sb_check("hit");

        // Restart from WIN, pause and resume.
        press(c);
        e3 = c + 4;
        exp_q.push_back(K_CLR + e3);
        exp_q.push_back(K_SERVE + e3 + 8);
        exp_q.push_back(e3 + 12);
        exp_q.push_back(e3 + 16);
        exp_q.push_back(e3 + 20);
        wait_until(e3);
        chk("win restart state", state, 1);
        chk("win restart lives", lives, 2);
        wait_until(e3 + 17);
        press(c);
        wait_until(e3 + 21);
        chk("pause state", state, 3);
        wait_until(e3 + 61);
        sb_check("pause");
        chk("pause hold state", state, 3);
        press(c);
        exp_q.push_back(e3 + 69);
        exp_q.push_back(e3 + 73);
        wait_until(e3 + 65);
        chk("resume state", state, 2);
        wait_until(e3 + 74);
        sb_check("resume");

        // Lose a life, then reset asynchronously in SERVE.
        row = 4'd14; col = 4'd0; pad = 4'd4;
        wait_until(e3 + 77);
        chk("miss3 state", state, 4);
        chk("miss3 lives", lives, 1);
        row = 4'd0;
        wait_until(e3 + 87);
        chk("pre-reset state", state, 1);
        chk("pre-reset lives", lives, 1);
        rst_n = 1'b0;
        #1;
        chk("async reset state", state, 0);
        chk("async reset lives", lives, 2);
        chk("async reset step_en", step_en, 0);
        chk("async reset serve", serve, 0);
        chk("async reset score_clr_n", score_clr_n, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_until(cyc + 20);
        chk("post-reset state", state, 0);
        sb_check("reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
